// File: rtl/uart_ctrl_pkg.sv
// UART TX arbiter shared definitions.
// Register map, FIFO status bit and controller FSM states.
package uart_ctrl_pkg;

    localparam logic [31:0] SETUP_OFF  = 32'h0;
    localparam logic [31:0] FIFO_OFF   = 32'h4;
    localparam logic [31:0] TXDATA_OFF = 32'hC;

    localparam int TX_SPACE_BIT = 16;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        SETUP_WR,
        SETUP_B,
        IDLE,
        POLL_AR,
        POLL_R,
        DATA_WR,
        DATA_B
    } state_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bundle between the arbiter and the UART slave.
// Master drives addresses, data, valids and response readies.
interface AXI_LITE #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [2:0]              aw_prot;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    w_ready;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [2:0]              ar_prot;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_valid;
    logic                    r_ready;

    modport Master (
        output aw_addr, aw_prot, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_valid,
        input  w_ready,
        input  b_resp, b_valid,
        output b_ready,
        output ar_addr, ar_prot, ar_valid,
        input  ar_ready,
        input  r_data, r_resp, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_addr, aw_prot, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_valid,
        output w_ready,
        output b_resp, b_valid,
        input  b_ready,
        input  ar_addr, ar_prot, ar_valid,
        output ar_ready,
        output r_data, r_resp, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant.
// Pointer only advances when the caller takes the grant.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NREQ-1:0] req_i,
    input  logic            update_i,
    output logic [NREQ-1:0] grant_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] gidx;
    logic [IW-1:0] idx;

    // Walk offsets high to low so the nearest requester wins last.
    always_comb begin
        grant_o = '0;
        gidx    = ptr_q;
        idx     = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = IW'((int'(ptr_q) + i) % NREQ);
            if (req_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
                gidx         = idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= IW'(NREQ - 1);
        end else if (update_i && |req_i) begin
            ptr_q <= gidx;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates byte requesters onto one AXI-Lite UART:
// configure once, then poll FIFO space and write TXDATA per byte.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int          AXI_ADDR_WIDTH = 32,
    parameter int          NREQ           = 2,
    parameter logic [31:0] UART_BASE      = 32'h0,
    parameter logic [31:0] UART_SETUP     = 32'd868
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [NREQ*8-1:0] req_data_i,
    output logic [NREQ-1:0] req_ready_o,
    AXI_LITE.Master         axil_master,
    output logic            err_o,
    output logic            busy_o
);

    localparam logic [AXI_ADDR_WIDTH-1:0] SETUP_ADDR =
        AXI_ADDR_WIDTH'(UART_BASE + SETUP_OFF);
    localparam logic [AXI_ADDR_WIDTH-1:0] FIFO_ADDR =
        AXI_ADDR_WIDTH'(UART_BASE + FIFO_OFF);
    localparam logic [AXI_ADDR_WIDTH-1:0] TXDATA_ADDR =
        AXI_ADDR_WIDTH'(UART_BASE + TXDATA_OFF);

    state_t                    state_q;
    logic [7:0]                byte_q;
    logic                      setup_issued_q;
    logic                      aw_valid_q;
    logic                      w_valid_q;
    logic                      b_ready_q;
    logic                      ar_valid_q;
    logic                      r_ready_q;
    logic                      err_q;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]               w_data_q;

    logic [NREQ-1:0] grant;
    logic [7:0]      grant_byte;
    logic            take;
    logic            aw_fire;
    logic            w_fire;
    logic            ar_fire;
    logic            r_fire;
    logic            b_fire;
    logic            space_ok;

    assign take = (state_q == IDLE) && |req_valid_i;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_valid_i),
        .update_i (take),
        .grant_o  (grant)
    );

    always_comb begin
        grant_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_byte |= req_data_i[i*8 +: 8];
        end
    end

    assign req_ready_o = take ? grant : '0;
    assign busy_o      = (state_q != IDLE);
    assign err_o       = err_q;

    assign aw_fire = aw_valid_q && axil_master.aw_ready;
    assign w_fire  = w_valid_q && axil_master.w_ready;
    assign ar_fire = ar_valid_q && axil_master.ar_ready;
    assign r_fire  = r_ready_q && axil_master.r_valid;
    assign b_fire  = b_ready_q && axil_master.b_valid;

    // An errored poll never counts as free space.
    assign space_ok = (axil_master.r_resp == RESP_OKAY) &&
                      axil_master.r_data[TX_SPACE_BIT];

    assign axil_master.aw_addr  = aw_addr_q;
    assign axil_master.aw_prot  = 3'b000;
    assign axil_master.aw_valid = aw_valid_q;
    assign axil_master.w_data   = w_data_q;
    assign axil_master.w_strb   = '1;
    assign axil_master.w_valid  = w_valid_q;
    assign axil_master.b_ready  = b_ready_q;
    assign axil_master.ar_addr  = FIFO_ADDR;
    assign axil_master.ar_prot  = 3'b000;
    assign axil_master.ar_valid = ar_valid_q;
    assign axil_master.r_ready  = r_ready_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= SETUP_WR;
            byte_q         <= '0;
            setup_issued_q <= 1'b0;
            aw_valid_q     <= 1'b0;
            w_valid_q      <= 1'b0;
            b_ready_q      <= 1'b0;
            ar_valid_q     <= 1'b0;
            r_ready_q      <= 1'b0;
            err_q          <= 1'b0;
            aw_addr_q      <= '0;
            w_data_q       <= '0;
        end else begin
            unique case (state_q)
                SETUP_WR, DATA_WR: begin
                    if (state_q == SETUP_WR && !setup_issued_q) begin
                        setup_issued_q <= 1'b1;
                        aw_valid_q     <= 1'b1;
                        w_valid_q      <= 1'b1;
                        aw_addr_q      <= SETUP_ADDR;
                        w_data_q       <= UART_SETUP;
                    end else begin
                        if (aw_fire) aw_valid_q <= 1'b0;
                        if (w_fire) w_valid_q <= 1'b0;
                        if ((aw_fire || !aw_valid_q) &&
                            (w_fire || !w_valid_q)) begin
                            b_ready_q <= 1'b1;
                            if (state_q == SETUP_WR) state_q <= SETUP_B;
                            else state_q <= DATA_B;
                        end
                    end
                end
                SETUP_B, DATA_B: begin
                    if (b_fire) begin
                        b_ready_q <= 1'b0;
                        if (axil_master.b_resp != RESP_OKAY) err_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (take) begin
                        byte_q     <= grant_byte;
                        ar_valid_q <= 1'b1;
                        state_q    <= POLL_AR;
                    end
                end
                POLL_AR: begin
                    if (ar_fire) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= POLL_R;
                    end
                end
                POLL_R: begin
                    if (r_fire) begin
                        r_ready_q <= 1'b0;
                        if (axil_master.r_resp != RESP_OKAY) err_q <= 1'b1;
                        if (space_ok) begin
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            aw_addr_q  <= TXDATA_ADDR;
                            w_data_q   <= {24'h0, byte_q};
                            state_q    <= DATA_WR;
                        end else begin
                            ar_valid_q <= 1'b1;
                            state_q    <= POLL_AR;
                        end
                    end
                end
                default: state_q <= SETUP_WR;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: AXI-Lite slave model logs transactions,
// scenario tasks queue expected transactions and compare them.
module tb_uart_tx_arbiter;

    localparam int NREQ = 2;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NREQ-1:0]   req_valid_i = '0;
    logic [NREQ*8-1:0] req_data_i = '0;
    logic [NREQ-1:0]   req_ready_o;
    logic              err_o;
    logic              busy_o;

    int tests_run = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    AXI_LITE #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axil ();

    uart_tx_arbiter #(
        .AXI_ADDR_WIDTH (32),
        .NREQ           (NREQ),
        .UART_BASE      (32'h0),
        .UART_SETUP     (32'd868)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .axil_master (axil),
        .err_o       (err_o),
        .busy_o      (busy_o)
    );

    // ---------------- slave model ----------------
    int          aw_delay = 0;
    int          full_until = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    int          aw_wait;
    int          reads_total = 0;
    logic        have_aw, have_w;
    logic [31:0] waddr, wdata;
    logic        b_valid_s, r_valid_s;
    logic [1:0]  b_resp_s;
    logic [31:0] r_data_s;
    txn_t        obs_q[$];
    txn_t        exp_q[$];

    wire aw_hit = axil.aw_valid && axil.aw_ready;
    wire w_hit  = axil.w_valid && axil.w_ready;
    wire ar_hit = axil.ar_valid && axil.ar_ready;

    assign axil.aw_ready = (aw_wait >= aw_delay);
    assign axil.w_ready  = 1'b1;
    assign axil.ar_ready = 1'b1;
    assign axil.b_valid  = b_valid_s;
    assign axil.b_resp   = b_resp_s;
    assign axil.r_valid  = r_valid_s;
    assign axil.r_data   = r_data_s;
    assign axil.r_resp   = 2'b00;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_valid_s <= 1'b0;
            r_valid_s <= 1'b0;
            b_resp_s  <= 2'b00;
            r_data_s  <= '0;
            have_aw   <= 1'b0;
            have_w    <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            aw_wait   <= 0;
        end else begin
            if (b_valid_s && axil.b_ready) b_valid_s <= 1'b0;
            if (r_valid_s && axil.r_ready) r_valid_s <= 1'b0;
            if (axil.aw_valid && !axil.aw_ready) aw_wait <= aw_wait + 1;
            else aw_wait <= 0;
            if (aw_hit) begin
                have_aw <= 1'b1;
                waddr   <= axil.aw_addr;
            end
            if (w_hit) begin
                have_w <= 1'b1;
                wdata  <= axil.w_data;
            end
            if ((have_aw || aw_hit) && (have_w || w_hit)) begin
                have_aw   <= 1'b0;
                have_w    <= 1'b0;
                b_valid_s <= 1'b1;
                b_resp_s  <= bresp_cfg;
                obs_q.push_back(txn_t'{1'b1,
                    aw_hit ? axil.aw_addr : waddr,
                    w_hit ? axil.w_data : wdata});
            end
            if (ar_hit) begin
                r_valid_s <= 1'b1;
                r_data_s  <= (reads_total < full_until) ?
                             32'h0 : 32'h0001_0000;
                reads_total <= reads_total + 1;
                obs_q.push_back(txn_t'{1'b0, axil.ar_addr, 32'h0});
            end
        end
    end

    // ---------------- monitors ----------------
    int   cyc = 0;
    int   grant_cnt = 0;
    int   b_cnt = 0;
    int   viol = 0;
    int   grant_cyc_q[$];
    logic aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
    logic [31:0] aw_addr_p, w_data_p;

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (rst_ni) begin
            if (|req_ready_o) begin
                grant_cnt <= grant_cnt + 1;
                grant_cyc_q.push_back(cyc);
            end
            if (axil.b_valid && axil.b_ready) b_cnt <= b_cnt + 1;
        end
    end

    // Valids must stay up with stable payload until accepted.
    always @(negedge clk_i) begin
        if (rst_ni && ((aw_pend && (!axil.aw_valid ||
                                    axil.aw_addr != aw_addr_p)) ||
                       (w_pend && (!axil.w_valid ||
                                   axil.w_data != w_data_p)) ||
                       (ar_pend && !axil.ar_valid) ||
                       ((req_ready_o & (req_ready_o - 1'b1)) != '0)))
            viol <= viol + 1;
        aw_pend   <= rst_ni && axil.aw_valid && !axil.aw_ready;
        w_pend    <= rst_ni && axil.w_valid && !axil.w_ready;
        ar_pend   <= rst_ni && axil.ar_valid && !axil.ar_ready;
        aw_addr_p <= axil.aw_addr;
        w_data_p  <= axil.w_data;
    end

    // ---------------- wait helpers ----------------
    task automatic wait_grants(input int target, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_i);
            if (grant_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_obs(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_i);
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [4:0] axi_ctl();
        return {axil.aw_valid, axil.w_valid, axil.ar_valid,
                axil.b_ready, axil.r_ready};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit   ok;
        txn_t e, o;
        rst_ni = 1'b0;
        req_valid_i = '0;
        repeat (3) @(negedge clk_i);
        tests_run += 4;
        if (busy_o !== 1'b1) begin
            fails++;
            $display("FAIL rst_busy: got %b want 1", busy_o);
        end
        if (err_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_err: got %b want 0", err_o);
        end
        if (req_ready_o !== '0) begin
            fails++;
            $display("FAIL rst_ready: got %b want 0", req_ready_o);
        end
        if (axi_ctl() !== 5'b0) begin
            fails++;
            $display("FAIL rst_axi: got %b want 00000", axi_ctl());
        end
        rst_ni = 1'b1;
        exp_q.push_back(txn_t'{1'b1, 32'h0, 32'h364});
        wait_obs(1, ok);
        repeat (6) @(negedge clk_i);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            if (o !== e) begin
                fails++;
                $display("FAIL setup_txn: got %h want %h", o, e);
            end
        end
        tests_run += 2;
        if (obs_q.size() !== 0) begin
            fails++;
            $display("FAIL setup_extra: got %0d extra want 0",
                     obs_q.size());
            obs_q.delete();
        end
        if (busy_o !== 1'b0) begin
            fails++;
            $display("FAIL setup_idle: busy got %b want 0", busy_o);
        end
    endtask

    task automatic test_round_robin();
        bit   ok;
        int   base;
        txn_t e, o;
        base = grant_cnt;
        grant_cyc_q.delete();
        req_data_i  = {8'h42, 8'h41};
        req_valid_i = 2'b11;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(txn_t'{1'b0, 32'h4, 32'h0});
            exp_q.push_back(txn_t'{1'b1, 32'hC,
                (k % 2 == 0) ? 32'h41 : 32'h42});
        end
        wait_grants(base + 6, ok);
        req_valid_i = '0;
        tests_run++;
        if (!ok) begin
            fails++;
            $display("FAIL rr_grants: got %0d want %0d",
                     grant_cnt - base, 6);
        end
        wait_obs(12, ok);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            if (o !== e) begin
                fails++;
                $display("FAIL rr_txn: got %h want %h", o, e);
            end
        end
        for (int k = 1; k < 6 && k < grant_cyc_q.size(); k++) begin
            tests_run++;
            if (grant_cyc_q[k] - grant_cyc_q[k-1] !== 5) begin
                fails++;
                $display("FAIL rr_gap: got %0d want 5",
                         grant_cyc_q[k] - grant_cyc_q[k-1]);
            end
        end
    endtask

    task automatic test_poll_full();
        bit   ok;
        int   base;
        txn_t e, o;
        base = grant_cnt;
        full_until = reads_total + 3;
        req_data_i[7:0] = 8'h55;
        req_valid_i = 2'b01;
        for (int k = 0; k < 4; k++)
            exp_q.push_back(txn_t'{1'b0, 32'h4, 32'h0});
        exp_q.push_back(txn_t'{1'b1, 32'hC, 32'h55});
        wait_grants(base + 1, ok);
        req_valid_i = '0;
        wait_obs(5, ok);
        repeat (10) @(negedge clk_i);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            if (o !== e) begin
                fails++;
                $display("FAIL poll_txn: got %h want %h", o, e);
            end
        end
        tests_run++;
        if (obs_q.size() !== 0) begin
            fails++;
            $display("FAIL poll_extra: got %0d extra want 0",
                     obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_aw_delay();
        bit   ok;
        int   base, bbase, w_cyc, aw_only;
        txn_t e, o;
        base  = grant_cnt;
        bbase = b_cnt;
        w_cyc = 0;
        aw_only = 0;
        aw_delay = 3;
        req_data_i[15:8] = 8'h66;
        req_valid_i = 2'b10;
        exp_q.push_back(txn_t'{1'b0, 32'h4, 32'h0});
        exp_q.push_back(txn_t'{1'b1, 32'hC, 32'h66});
        wait_grants(base + 1, ok);
        req_valid_i = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (axil.w_valid) w_cyc++;
            if (axil.aw_valid && !axil.w_valid) aw_only++;
            if (b_cnt > bbase) break;
        end
        repeat (4) @(negedge clk_i);
        aw_delay = 0;
        tests_run += 3;
        if (w_cyc !== 1) begin
            fails++;
            $display("FAIL awd_w_cycles: got %0d want 1", w_cyc);
        end
        if (aw_only !== 3) begin
            fails++;
            $display("FAIL awd_aw_hold: got %0d want 3", aw_only);
        end
        if (b_cnt - bbase !== 1) begin
            fails++;
            $display("FAIL awd_b_count: got %0d want 1", b_cnt - bbase);
        end
        wait_obs(2, ok);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            if (o !== e) begin
                fails++;
                $display("FAIL awd_txn: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_bresp_err();
        bit   ok, seen;
        int   base;
        txn_t e, o;
        base = grant_cnt;
        seen = 1'b0;
        bresp_cfg = 2'b10;
        req_data_i[7:0] = 8'h77;
        req_valid_i = 2'b01;
        exp_q.push_back(txn_t'{1'b0, 32'h4, 32'h0});
        exp_q.push_back(txn_t'{1'b1, 32'hC, 32'h77});
        wait_grants(base + 1, ok);
        req_valid_i = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (axil.b_valid && axil.b_ready) begin
                seen = 1'b1;
                break;
            end
        end
        tests_run += 4;
        if (!seen || err_o !== 1'b0) begin
            fails++;
            $display("FAIL err_before: seen %b err %b want 1/0",
                     seen, err_o);
        end
        @(negedge clk_i);
        bresp_cfg = 2'b00;
        if (err_o !== 1'b1) begin
            fails++;
            $display("FAIL err_rise: got %b want 1", err_o);
        end
        if (busy_o !== 1'b0) begin
            fails++;
            $display("FAIL err_idle: busy got %b want 0", busy_o);
        end
        repeat (5) @(negedge clk_i);
        if (err_o !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky: got %b want 1", err_o);
        end
        wait_obs(2, ok);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            if (o !== e) begin
                fails++;
                $display("FAIL err_txn: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit   ok, seen;
        int   base;
        txn_t e, o;
        base = grant_cnt;
        seen = 1'b0;
        req_data_i[15:8] = 8'h88;
        req_valid_i = 2'b10;
        exp_q.push_back(txn_t'{1'b0, 32'h4, 32'h0});
        exp_q.push_back(txn_t'{1'b1, 32'hC, 32'h88});
        wait_grants(base + 1, ok);
        req_valid_i = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (axil.b_ready) begin
                seen = 1'b1;
                break;
            end
        end
        rst_ni = 1'b0;
        #1;
        tests_run += 5;
        if (!seen) begin
            fails++;
            $display("FAIL mid_data_b: got 0 want 1");
        end
        if (busy_o !== 1'b1) begin
            fails++;
            $display("FAIL mid_busy: got %b want 1", busy_o);
        end
        if (err_o !== 1'b0) begin
            fails++;
            $display("FAIL mid_err: got %b want 0", err_o);
        end
        if (req_ready_o !== '0) begin
            fails++;
            $display("FAIL mid_ready: got %b want 0", req_ready_o);
        end
        if (axi_ctl() !== 5'b0) begin
            fails++;
            $display("FAIL mid_axi: got %b want 00000", axi_ctl());
        end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        exp_q.push_back(txn_t'{1'b1, 32'h0, 32'h364});
        wait_obs(3, ok);
        base = grant_cnt;
        req_data_i  = {8'hAA, 8'h99};
        req_valid_i = 2'b11;
        exp_q.push_back(txn_t'{1'b0, 32'h4, 32'h0});
        exp_q.push_back(txn_t'{1'b1, 32'hC, 32'h99});
        wait_grants(base + 1, ok);
        req_valid_i = '0;
        wait_obs(5, ok);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            if (o !== e) begin
                fails++;
                $display("FAIL mid_txn: got %h want %h", o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_poll_full();
        test_aw_delay();
        test_bresp_err();
        test_reset_mid();
        repeat (5) @(negedge clk_i);
        tests_run++;
        if (viol !== 0) begin
            fails++;
            $display("FAIL protocol: got %0d violations want 0", viol);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
